// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported 32-word data memory between the pipeline MEM stage
// (port 0) and the debug/DMA loader (port 1). At most one access is granted
// per cycle. The granted port drives the memory address, write data and write
// enable combinationally. Read data comes back registered, with a one-cycle
// valid pulse. Port 0 sees a stall whenever it requests and loses.
//
// Ports
//   CLK, Reset           clock (posedge) and asynchronous active-high reset
//   pN_req/we/addr/wdata requester N access (hold until pN_gnt is seen)
//   p1_lock              port 1 asks to keep the memory for a burst
//   pN_gnt               combinational grant for the current cycle
//   p0_stall             port 0 requested but was not granted
//   pN_rvalid/rdata      registered read return (rdata held between reads)
//   pN_err               registered pulse: granted address outside the memory
//   mem_ra/wa/di/wr      memory read/write address, write data, write enable
//   mem_do               memory asynchronous read data
//
// Configuration macro
//   DMEM_ARB_RR_EN  defined   : round-robin between the ports (no starvation
//                               counter is built)
//                   undefined : fixed priority to port 0, with a starvation
//                               guard that forces a port 1 grant
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW         = 5,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int LOCK_MAX   = 8
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [31:0]   p0_addr,
   input  logic [DW-1:0] p0_wdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [31:0]   p1_addr,
   input  logic [DW-1:0] p1_wdata,
   input  logic          p1_lock,
   output logic          p0_gnt,
   output logic          p1_gnt,
   output logic          p0_stall,
   output logic          p0_rvalid,
   output logic          p1_rvalid,
   output logic [DW-1:0] p0_rdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p0_err,
   output logic          p1_err,
   output logic [31:0]   mem_ra,
   output logic [31:0]   mem_wa,
   output logic [DW-1:0] mem_di,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_do
);

   localparam int LCW = $clog2(LOCK_MAX + 1);

   // The lock can be idle, held by port 1, or cooling down after it ended.
   // While cooling down port 1 may still be granted, but it cannot start a
   // new lock until port 0 has been served or has been idle for a cycle.
   typedef enum logic [1:0] {
      LK_IDLE,
      LK_HELD,
      LK_COOL
   } lock_state_t;

   lock_state_t    lock_state;
   logic [LCW-1:0] lock_cnt;
   logic [LCW-1:0] lock_next;
   logic           lock_active;
   logic           lock_take;
   logic           p0_inrange;
   logic           p1_inrange;
   logic [AW-1:0]  sel_word;

   assign lock_active = (lock_state == LK_HELD);
   assign lock_next   = lock_cnt + LCW'(1);
   assign p0_inrange  = (p0_addr[31:AW] == '0);
   assign p1_inrange  = (p1_addr[31:AW] == '0);

   // A port 1 grant with p1_lock either continues the current lock or starts
   // a new one, unless the lock is still cooling down.
   assign lock_take = p1_gnt & p1_lock & (lock_state != LK_COOL);

`ifdef DMEM_ARB_RR_EN
   logic last_owner;
`else
   localparam int SCW = $clog2(STARVE_MAX + 1);
   logic [SCW-1:0] starve_cnt;
   logic           starve_full;
   assign starve_full = (starve_cnt == SCW'(STARVE_MAX));
`endif

   // Grant decision. An active lock always wins for port 1. After that either
   // the starvation guard plus fixed priority, or round-robin when both ask.
   // Nothing is granted while Reset is high.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!Reset) begin
         if (lock_active && p1_req) begin
            p1_gnt = 1'b1;
`ifdef DMEM_ARB_RR_EN
         end else if (p0_req && p1_req) begin
            if (last_owner) begin
               p0_gnt = 1'b1;
            end else begin
               p1_gnt = 1'b1;
            end
`else
         end else if (p1_req && starve_full) begin
            p1_gnt = 1'b1;
`endif
         end else if (p0_req) begin
            p0_gnt = 1'b1;
         end else if (p1_req) begin
            p1_gnt = 1'b1;
         end
      end
   end

   assign p0_stall = p0_req & ~p0_gnt & ~Reset;

   // Memory drive from whichever port holds the grant. Only the decoded word
   // bits reach the memory, and out-of-range writes never assert mem_wr.
   always_comb begin
      sel_word = '0;
      mem_di   = '0;
      mem_wr   = 1'b0;
      if (p1_gnt) begin
         sel_word = p1_addr[AW-1:0];
         mem_di   = p1_wdata;
         mem_wr   = p1_we & p1_inrange;
      end else if (p0_gnt) begin
         sel_word = p0_addr[AW-1:0];
         mem_di   = p0_wdata;
         mem_wr   = p0_we & p0_inrange;
      end
   end

   assign mem_ra = {{(32-AW){1'b0}}, sel_word};
   assign mem_wa = {{(32-AW){1'b0}}, sel_word};

   // Lock bookkeeping. The grant that brings lock_cnt up to LOCK_MAX is the
   // last locked grant. Any other break in the burst (lock dropped, request
   // dropped) also ends the lock and enters the cool-down.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         lock_state <= LK_IDLE;
         lock_cnt   <= '0;
      end else if (lock_take) begin
         if (lock_next == LCW'(LOCK_MAX)) begin
            lock_state <= LK_COOL;
            lock_cnt   <= '0;
         end else begin
            lock_state <= LK_HELD;
            lock_cnt   <= lock_next;
         end
      end else if (lock_state == LK_HELD) begin
         lock_state <= LK_COOL;
         lock_cnt   <= '0;
      end else if (lock_state == LK_COOL && (p0_gnt || !p0_req)) begin
         lock_state <= LK_IDLE;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Remember who was served last so that contention alternates.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         last_owner <= 1'b0;
      end else if (p1_gnt) begin
         last_owner <= 1'b1;
      end else if (p0_gnt) begin
         last_owner <= 1'b0;
      end
   end
`else
   // Count the consecutive cycles port 1 waits. Once the count saturates
   // at STARVE_MAX, port 1 is pushed ahead of port 0 for one grant.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         starve_cnt <= '0;
      end else if (!p1_req || p1_gnt) begin
         starve_cnt <= '0;
      end else if (!starve_full) begin
         starve_cnt <= starve_cnt + SCW'(1);
      end
   end
`endif

   // Read return for port 0. Out-of-range reads return zero instead of the
   // aliased memory word, and flag err. Writes never raise rvalid.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         p0_rvalid <= 1'b0;
         p0_err    <= 1'b0;
         p0_rdata  <= '0;
      end else begin
         p0_rvalid <= p0_gnt & ~p0_we;
         p0_err    <= p0_gnt & ~p0_inrange;
         if (p0_gnt && !p0_we) begin
            p0_rdata <= p0_inrange ? mem_do : '0;
         end
      end
   end

   // Read return for port 1, same behaviour as port 0.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         p1_rvalid <= 1'b0;
         p1_err    <= 1'b0;
         p1_rdata  <= '0;
      end else begin
         p1_rvalid <= p1_gnt & ~p1_we;
         p1_err    <= p1_gnt & ~p1_inrange;
         if (p1_gnt && !p1_we) begin
            p1_rdata <= p1_inrange ? mem_do : '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Testbench for dmem_arbiter. A 32-word memory model hangs off the memory
// port. It writes on negedge and reads asynchronously. Directed scenarios
// cover reset, write/read, priority/starvation (or round-robin), lock bursts
// and out-of-range addresses. A randomized run is then compared against a
// cycle-level reference model of the arbitration rules. Build with
// DMEM_ARB_RR_EN defined to exercise the round-robin variant.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW         = 5;
   localparam int DW         = 32;
   localparam int STARVE_MAX = 4;
   localparam int LOCK_MAX   = 8;

   logic          clk = 1'b0;
   logic          Reset = 1'b1;
   logic          p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0]   p0_addr = '0;
   logic [DW-1:0] p0_wdata = '0;
   logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
   logic [31:0]   p1_addr = '0;
   logic [DW-1:0] p1_wdata = '0;
   logic          p0_gnt, p1_gnt, p0_stall;
   logic          p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic [31:0]   mem_ra, mem_wa;
   logic [DW-1:0] mem_di, mem_do;
   logic          mem_wr;

   logic [DW-1:0] ram [32] = '{default: '0};

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic          m_lock = 1'b0;
   int            m_lock_cnt = 0;
   logic          m_block = 1'b0;
   int            m_starve = 0;
   logic          m_last = 1'b0;
   logic [DW-1:0] ref_mem [32];
   logic          e_rv0, e_rv1, e_err0, e_err1;
   logic [DW-1:0] e_rd0, e_rd1;

   always #5 clk = ~clk;

   // Memory model: writes land on the falling edge and reads are combinational.
   always @(negedge clk) begin
      if (mem_wr) ram[mem_wa[4:0]] <= mem_di;
   end
   assign mem_do = ram[mem_ra[4:0]];

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
      .CLK(clk), .Reset(Reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_lock(p1_lock),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_stall(p0_stall),
      .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .p0_err(p0_err), .p1_err(p1_err),
      .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_di(mem_di), .mem_wr(mem_wr),
      .mem_do(mem_do)
   );

   // Advance to 1 ns after the next rising edge, where inputs get driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_p0(input logic req, input logic we, input logic [31:0] a,
                         input logic [DW-1:0] d);
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
   endtask

   task automatic set_p1(input logic req, input logic we, input logic [31:0] a,
                         input logic [DW-1:0] d, input logic lk);
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = lk;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[31:AW] = 27'($urandom_range(1, 200));
      return a;
   endfunction

   // Grant the spec's priority list would give this cycle, as {g1, g0}.
   function automatic logic [1:0] model_grant();
      if (m_lock && p1_req) return 2'b10;
`ifdef DMEM_ARB_RR_EN
      if (p0_req && p1_req) return m_last ? 2'b01 : 2'b10;
`else
      if (p1_req && m_starve == STARVE_MAX) return 2'b10;
`endif
      if (p0_req) return 2'b01;
      if (p1_req) return 2'b10;
      return 2'b00;
   endfunction

   // Update the model at the clock edge that ends the current cycle.
   task automatic model_commit(input logic [1:0] g);
      e_rv0  = g[0] && !p0_we;
      e_err0 = g[0] && (p0_addr >= 32);
      if (g[0] && !p0_we) e_rd0 = (p0_addr < 32) ? ref_mem[p0_addr[4:0]] : '0;
      if (g[0] && p0_we && p0_addr < 32) ref_mem[p0_addr[4:0]] = p0_wdata;
      e_rv1  = g[1] && !p1_we;
      e_err1 = g[1] && (p1_addr >= 32);
      if (g[1] && !p1_we) e_rd1 = (p1_addr < 32) ? ref_mem[p1_addr[4:0]] : '0;
      if (g[1] && p1_we && p1_addr < 32) ref_mem[p1_addr[4:0]] = p1_wdata;
`ifdef DMEM_ARB_RR_EN
      if (g[0]) m_last = 1'b0;
      if (g[1]) m_last = 1'b1;
`else
      if (!p1_req || g[1]) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
`endif
      if (g[1] && p1_lock && (m_lock || !m_block)) begin
         m_lock_cnt = m_lock_cnt + 1;
         if (m_lock_cnt == LOCK_MAX) begin
            m_lock = 1'b0; m_lock_cnt = 0; m_block = 1'b1;
         end else begin
            m_lock = 1'b1;
         end
      end else if (m_lock) begin
         m_lock = 1'b0; m_lock_cnt = 0; m_block = 1'b1;
      end else if (m_block && (g[0] || !p0_req)) begin
         m_block = 1'b0;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      set_p0(1'b1, 1'b0, 32'd3, '0);
      set_p1(1'b0, 1'b0, '0, '0, 1'b0);
      #2;
      n_cmp++;
      if ({p0_gnt, p1_gnt, p0_stall, mem_wr, p0_rvalid, p1_rvalid, p0_err, p1_err} !== 8'h00) begin
         n_bad++;
         $display("[TB] FAIL reset_flags: got %b want 00000000",
                  {p0_gnt, p1_gnt, p0_stall, mem_wr, p0_rvalid, p1_rvalid, p0_err, p1_err});
      end
      n_cmp++;
      if ({mem_ra, mem_wa} !== 64'h0) begin
         n_bad++; $display("[TB] FAIL reset_addr: got %h/%h want 0/0", mem_ra, mem_wa);
      end
      n_cmp++;
      if ({p0_rdata, p1_rdata} !== 64'h0) begin
         n_bad++; $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata);
      end
      tick();
      Reset = 1'b0;
      #2;
      n_cmp++;
      if (p0_gnt !== 1'b1 || mem_ra !== 32'd3) begin
         n_bad++; $display("[TB] FAIL reset_release_grant: got gnt=%b ra=%h want 1/3", p0_gnt, mem_ra);
      end
      #1;
      Reset = 1'b1;
      #1;
      n_cmp++;
      if (p0_gnt !== 1'b0) begin
         n_bad++; $display("[TB] FAIL reset_async_gnt: got %b want 0", p0_gnt);
      end
      tick();
      Reset = 1'b0;
      set_p0(1'b0, 1'b0, '0, '0);
      #2;
      n_cmp++;
      if (p0_rvalid !== 1'b0) begin
         n_bad++; $display("[TB] FAIL reset_mid_read_rvalid: got %b want 0", p0_rvalid);
      end
      tick();
      #2;
      n_cmp++;
      if (p0_rvalid !== 1'b0 || p0_rdata !== '0) begin
         n_bad++; $display("[TB] FAIL reset_after_idle: got rv=%b rd=%h want 0/0", p0_rvalid, p0_rdata);
      end
   endtask

   task automatic test_write_read();
      tick();
      set_p0(1'b1, 1'b1, 32'd7, 32'hDEADBEEF);
      #2;
      n_cmp++;
      if ({p0_gnt, mem_wr} !== 2'b11 || mem_wa !== 32'd7 || mem_di !== 32'hDEADBEEF) begin
         n_bad++;
         $display("[TB] FAIL wr_drive: got gnt=%b wr=%b wa=%h di=%h want 1/1/7/deadbeef",
                  p0_gnt, mem_wr, mem_wa, mem_di);
      end
      tick();
      set_p0(1'b1, 1'b0, 32'd7, '0);
      #2;
      n_cmp++;
      if (p0_rvalid !== 1'b0 || p0_gnt !== 1'b1) begin
         n_bad++; $display("[TB] FAIL wr_no_rvalid: got rv=%b gnt=%b want 0/1", p0_rvalid, p0_gnt);
      end
      tick();
      set_p0(1'b0, 1'b0, '0, '0);
      #2;
      n_cmp++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p0_err !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL rd_after_wr: got rv=%b rd=%h err=%b want 1/deadbeef/0",
                  p0_rvalid, p0_rdata, p0_err);
      end
      tick();
      #2;
      n_cmp++;
      if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin
         n_bad++; $display("[TB] FAIL rd_hold: got rv=%b rd=%h want 0/deadbeef", p0_rvalid, p0_rdata);
      end
   endtask

`ifndef DMEM_ARB_RR_EN
   task automatic test_starvation();
      logic exp1;
      tick();
      set_p0(1'b0, 1'b0, '0, '0);
      set_p1(1'b0, 1'b0, '0, '0, 1'b0);
      #2;
      for (int i = 0; i < 15; i++) begin
         tick();
         set_p0(1'b1, 1'b0, 32'd1, '0);
         set_p1(1'b1, 1'b0, 32'd2, '0, 1'b0);
         #2;
         exp1 = (i % 5 == 4);
         n_cmp++;
         if ({p1_gnt, p0_gnt, p0_stall} !== {exp1, ~exp1, exp1}) begin
            n_bad++;
            $display("[TB] FAIL starve_grant[%0d]: got g1=%b g0=%b stall=%b want %b/%b/%b",
                     i, p1_gnt, p0_gnt, p0_stall, exp1, ~exp1, exp1);
         end
         if (i > 0) begin
            n_cmp++;
            if (p1_rvalid !== (i % 5 == 0)) begin
               n_bad++;
               $display("[TB] FAIL starve_rvalid[%0d]: got %b want %b", i, p1_rvalid, (i % 5 == 0));
            end
         end
      end
   endtask
`else
   task automatic test_round_robin();
      logic exp0;
      tick();
      set_p0(1'b0, 1'b0, '0, '0);
      set_p1(1'b1, 1'b0, 32'd4, '0, 1'b0);
      #2;
      n_cmp++;
      if ({p0_gnt, p1_gnt} !== 2'b01) begin
         n_bad++; $display("[TB] FAIL rr_single: got %b%b want 01", p0_gnt, p1_gnt);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         set_p0(1'b1, 1'b0, 32'd1, '0);
         set_p1(1'b1, 1'b0, 32'd2, '0, 1'b0);
         #2;
         exp0 = (i % 2 == 0);
         n_cmp++;
         if ({p0_gnt, p1_gnt} !== {exp0, ~exp0}) begin
            n_bad++;
            $display("[TB] FAIL rr_alt[%0d]: got %b%b want %b%b", i, p0_gnt, p1_gnt, exp0, ~exp0);
         end
      end
   endtask
`endif

   task automatic test_lock();
      int   k1;
      logic p0_pend;
      logic exp0, exp1;
      int   bad_words;
      k1 = 0;
      p0_pend = 1'b0;
      tick();
      set_p0(1'b0, 1'b0, '0, '0);
      set_p1(1'b0, 1'b0, '0, '0, 1'b0);
      #2;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 1) p0_pend = 1'b1;
         set_p0(p0_pend, 1'b1, 32'd20, 32'h5555_0000);
         if (k1 < 10) set_p1(1'b1, 1'b1, 32'(k1), 32'hB000_0000 + 32'(k1), 1'b1);
         else         set_p1(1'b0, 1'b0, '0, '0, 1'b0);
         #2;
         exp1 = (i < 8) || (i == 9) || (i == 10);
         exp0 = (i == 8);
         n_cmp++;
         if ({p1_gnt, p0_gnt} !== {exp1, exp0}) begin
            n_bad++;
            $display("[TB] FAIL lock_grant[%0d]: got g1=%b g0=%b want %b/%b", i, p1_gnt, p0_gnt, exp1, exp0);
         end
         if (i >= 1 && i < 8) begin
            n_cmp++;
            if (p0_stall !== 1'b1) begin
               n_bad++; $display("[TB] FAIL lock_stall[%0d]: got %b want 1", i, p0_stall);
            end
         end
         if (p0_gnt) p0_pend = 1'b0;
         if (p1_gnt) k1++;
      end
      tick();
      #2;
      bad_words = 0;
      for (int a = 0; a < 10; a++) begin
         if (ram[a] !== 32'hB000_0000 + 32'(a)) bad_words++;
      end
      n_cmp++;
      if (bad_words != 0 || ram[20] !== 32'h5555_0000) begin
         n_bad++;
         $display("[TB] FAIL lock_data: got %0d bad burst words, ram[20]=%h want 0/55550000",
                  bad_words, ram[20]);
      end
   endtask

   task automatic test_out_of_range();
      tick();
      set_p0(1'b1, 1'b1, 32'd0, 32'hA5A5A5A5);
      #2;
      tick();
      set_p0(1'b1, 1'b1, 32'h20, 32'h12345678);
      #2;
      n_cmp++;
      if ({p0_gnt, mem_wr} !== 2'b10 || mem_wa !== 32'd0) begin
         n_bad++; $display("[TB] FAIL oor_wr_drive: got gnt=%b wr=%b wa=%h want 1/0/0", p0_gnt, mem_wr, mem_wa);
      end
      tick();
      set_p0(1'b1, 1'b0, 32'h40, '0);
      #2;
      n_cmp++;
      if ({p0_err, p0_rvalid} !== 2'b10) begin
         n_bad++; $display("[TB] FAIL oor_wr_err: got err=%b rv=%b want 1/0", p0_err, p0_rvalid);
      end
      tick();
      set_p0(1'b0, 1'b0, '0, '0);
      #2;
      n_cmp++;
      if ({p0_err, p0_rvalid} !== 2'b11 || p0_rdata !== '0) begin
         n_bad++;
         $display("[TB] FAIL oor_rd: got err=%b rv=%b rd=%h want 1/1/0", p0_err, p0_rvalid, p0_rdata);
      end
      n_cmp++;
      if (ram[0] !== 32'hA5A5A5A5) begin
         n_bad++; $display("[TB] FAIL oor_mem0: got %h want a5a5a5a5", ram[0]);
      end
      tick();
      #2;
      n_cmp++;
      if (p0_err !== 1'b0) begin
         n_bad++; $display("[TB] FAIL oor_err_pulse: got %b want 0", p0_err);
      end
   endtask

   task automatic test_random();
      logic          pend0, pend1, we0, we1, lk1, lk_mode;
      logic [31:0]   a0, a1, ea;
      logic [DW-1:0] d0, d1, ed;
      logic [1:0]    g;
      logic          ewr;
      pend0 = 1'b0; pend1 = 1'b0; lk_mode = 1'b0;
      we0 = 1'b0; we1 = 1'b0; lk1 = 1'b0;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      tick();
      set_p0(1'b0, 1'b0, '0, '0);
      set_p1(1'b0, 1'b0, '0, '0, 1'b0);
      Reset = 1'b1;
      #2;
      tick();
      Reset = 1'b0;
      m_lock = 1'b0; m_lock_cnt = 0; m_block = 1'b0; m_starve = 0; m_last = 1'b0;
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      for (int a = 0; a < 32; a++) ref_mem[a] = ram[a];
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 15) == 0) lk_mode = ~lk_mode;
         if (!pend0 && $urandom_range(0, 3) != 0) begin
            pend0 = 1'b1; we0 = 1'($urandom_range(0, 1)); a0 = rand_addr(); d0 = $urandom();
         end
         if (!pend1 && (lk_mode || $urandom_range(0, 2) != 0)) begin
            pend1 = 1'b1; we1 = 1'($urandom_range(0, 1)); a1 = rand_addr(); d1 = $urandom();
            lk1 = lk_mode;
         end
         set_p0(pend0, we0, a0, d0);
         set_p1(pend1, we1, a1, d1, lk1 & pend1);
         #2;
         n_cmp++;
         if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== {e_rv0, e_err0, e_rv1, e_err1}) begin
            n_bad++;
            $display("[TB] FAIL rand_flags[%0d]: got %b%b%b%b want %b%b%b%b", c,
                     p0_rvalid, p0_err, p1_rvalid, p1_err, e_rv0, e_err0, e_rv1, e_err1);
         end
         n_cmp++;
         if (p0_rdata !== e_rd0) begin
            n_bad++; $display("[TB] FAIL rand_p0_rdata[%0d]: got %h want %h", c, p0_rdata, e_rd0);
         end
         n_cmp++;
         if (p1_rdata !== e_rd1) begin
            n_bad++; $display("[TB] FAIL rand_p1_rdata[%0d]: got %h want %h", c, p1_rdata, e_rd1);
         end
         g = model_grant();
         n_cmp++;
         if ({p1_gnt, p0_gnt, p0_stall} !== {g, p0_req & ~g[0]}) begin
            n_bad++;
            $display("[TB] FAIL rand_grant[%0d]: got g1=%b g0=%b stall=%b want %b/%b/%b", c,
                     p1_gnt, p0_gnt, p0_stall, g[1], g[0], p0_req & ~g[0]);
         end
         ea = '0; ewr = 1'b0; ed = '0;
         if (g[1]) begin
            ea = p1_addr % 32; ewr = p1_we && (p1_addr < 32); ed = p1_wdata;
         end else if (g[0]) begin
            ea = p0_addr % 32; ewr = p0_we && (p0_addr < 32); ed = p0_wdata;
         end
         n_cmp++;
         if (mem_ra !== ea || mem_wa !== ea || mem_wr !== ewr) begin
            n_bad++;
            $display("[TB] FAIL rand_mem[%0d]: got ra=%h wa=%h wr=%b want %h/%h/%b", c,
                     mem_ra, mem_wa, mem_wr, ea, ea, ewr);
         end
         if (ewr) begin
            n_cmp++;
            if (mem_di !== ed) begin
               n_bad++; $display("[TB] FAIL rand_di[%0d]: got %h want %h", c, mem_di, ed);
            end
         end
         model_commit(g);
         if (g[0]) pend0 = 1'b0;
         if (g[1]) pend1 = 1'b0;
         tick();
      end
   endtask

   initial begin
      $display("[TB] dmem_arbiter bench start");
      test_reset();
      test_write_read();
`ifdef DMEM_ARB_RR_EN
      test_round_robin();
`else
      test_starvation();
`endif
      test_lock();
      test_out_of_range();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
